attacker_array: RTL and testbench

ATTACKER_ARRAY -- requirements
Module: attacker_array

---
 rtl/attacker_array.sv | 199 +++++++++++++++++++
 tb/tb_attacker_array.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attacker_array.sv
// attacker_array
//   Keeps NUM_ATK diagonal-flying attackers for a raster game.
//   Each attacker waits, launches at a staggered frame count, flies
//   down-left and respawns at its start position when it reaches the
//   left wall or the bottom limit. The speed level rises every
//   LEVEL_FRAMES frames. A collision with the shooter box freezes the
//   game until game_stop or clear.
//
// Ports
//   clk_65M       pixel clock, only clock
//   clear         asynchronous active-high reset
//   game_stop     synchronous restart request (level-sensitive)
//   H_count       raster column
//   V_count       raster row
//   vid_on        visible-area flag
//   shooter_xmid  shooter centre x
//   shooter_ymid  shooter centre y
//   atk_on_vec    per-attacker pixel hit at the current raster position
//   atk_on        OR of atk_on_vec
//   game_over     sticky collision flag
//   level         current speed level
//   respawn_cnt   saturating count of respawned attackers
module attacker_array #(
  parameter int NUM_ATK      = 4,
  parameter int ATK_SIZE     = 3,
  parameter int SHOOTER_SIZE = 10,
  parameter int X_START      = 627,
  parameter int X_SPACING    = 40,
  parameter int Y_START      = 49,
  parameter int Y_LIMIT      = 730,
  parameter int WALL_LEFT    = 180,
  parameter int XVEL         = 3,
  parameter int YVEL         = 2,
  parameter int LAUNCH_GAP   = 32,
  parameter int LEVEL_FRAMES = 600,
  parameter int MAX_LEVEL    = 3,
  parameter int HBP          = 296,
  parameter int VBP          = 35
) (
  input  logic               clk_65M,
  input  logic               clear,
  input  logic               game_stop,
  input  logic [16:0]        H_count,
  input  logic [16:0]        V_count,
  input  logic               vid_on,
  input  logic [16:0]        shooter_xmid,
  input  logic [16:0]        shooter_ymid,
  output logic [NUM_ATK-1:0] atk_on_vec,
  output logic               atk_on,
  output logic               game_over,
  output logic [1:0]         level,
  output logic [7:0]         respawn_cnt
);

  typedef enum logic {WAIT, FLY} atk_state_e;

  atk_state_e  state_q [NUM_ATK];
  atk_state_e  state_d [NUM_ATK];
  logic [16:0] x_q     [NUM_ATK];
  logic [16:0] x_d     [NUM_ATK];
  logic [16:0] y_q     [NUM_ATK];
  logic [16:0] y_d     [NUM_ATK];
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] lvl_cnt_q, lvl_cnt_d;
  logic [1:0]  level_q, level_d;
  logic [7:0]  resp_q, resp_d;
  logic        game_over_q, game_over_d;

  logic               frame_tick;
  logic [NUM_ATK-1:0] hit;
  logic [3:0]         resp_inc;
  logic [8:0]         resp_sum;
  logic [16:0]        step_x, step_y;
  logic [16:0]        sx_lo, sx_hi, sy_lo, sy_hi;

  function automatic logic [16:0] startX(input int idx);
    startX = 17'(X_START - idx * X_SPACING);
  endfunction

  assign frame_tick = (H_count == 17'd0) && (V_count == 17'd0);
  assign step_x     = 17'(XVEL) + 17'(level_q);
  assign step_y     = 17'(YVEL) + 17'(level_q);
  assign sx_lo      = shooter_xmid - 17'(SHOOTER_SIZE);
  assign sx_hi      = shooter_xmid + 17'(SHOOTER_SIZE);
  assign sy_lo      = shooter_ymid - 17'(SHOOTER_SIZE);
  assign sy_hi      = shooter_ymid + 17'(SHOOTER_SIZE);

  // State register; clear puts every attacker back in WAIT at its start.
  always_ff @(posedge clk_65M or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_ATK; i++) begin
        state_q[i] <= WAIT;
        x_q[i]     <= startX(i);
        y_q[i]     <= 17'(Y_START);
      end
      frame_cnt_q <= '0;
      lvl_cnt_q   <= '0;
      level_q     <= '0;
      resp_q      <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      lvl_cnt_q   <= lvl_cnt_d;
      level_q     <= level_d;
      resp_q      <= resp_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic. game_stop restarts at once; otherwise everything
  // advances only on the frame tick and only while the game is running.
  // A collision wins over respawn and movement for every attacker, and an
  // attacker launching on a tick also takes its first step on that tick.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    lvl_cnt_d   = lvl_cnt_q;
    level_d     = level_q;
    resp_d      = resp_q;
    game_over_d = game_over_q;
    resp_inc    = '0;
    resp_sum    = '0;
    hit         = '0;

    for (int i = 0; i < NUM_ATK; i++) begin
      hit[i] = (state_q[i] == FLY) &&
               (x_q[i] >= sx_lo) && ((x_q[i] + 17'(ATK_SIZE)) <= sx_hi) &&
               (y_q[i] >= sy_lo) && ((y_q[i] + 17'(ATK_SIZE)) <= sy_hi);
    end

    if (game_stop) begin
      for (int i = 0; i < NUM_ATK; i++) begin
        state_d[i] = WAIT;
        x_d[i]     = startX(i);
        y_d[i]     = 17'(Y_START);
      end
      frame_cnt_d = '0;
      lvl_cnt_d   = '0;
      level_d     = '0;
      resp_d      = '0;
      game_over_d = 1'b0;
    end else if (frame_tick && !game_over_q) begin
      // lvl_cnt_q tracks frame count modulo LEVEL_FRAMES so no divider is needed.
      if (frame_cnt_q != 16'hFFFF) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (lvl_cnt_q == 16'(LEVEL_FRAMES - 1)) begin
          lvl_cnt_d = '0;
          if (level_q < 2'(MAX_LEVEL)) begin
            level_d = level_q + 2'd1;
          end
        end else begin
          lvl_cnt_d = lvl_cnt_q + 16'd1;
        end
      end

      if (|hit) begin
        game_over_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_ATK; i++) begin
          if ((state_q[i] == FLY) || (frame_cnt_q == 16'(i * LAUNCH_GAP))) begin
            state_d[i] = FLY;
            if ((x_q[i] <= 17'(WALL_LEFT)) || (y_q[i] >= 17'(Y_LIMIT))) begin
              x_d[i]   = startX(i);
              y_d[i]   = 17'(Y_START);
              resp_inc = resp_inc + 4'd1;
            end else begin
              x_d[i] = x_q[i] - step_x;
              y_d[i] = y_q[i] + step_y;
            end
          end
        end
        resp_sum = {1'b0, resp_q} + 9'(resp_inc);
        resp_d   = resp_sum[8] ? 8'hFF : resp_sum[7:0];
      end
    end
  end

  // Output logic; pixel hits are gated by clear so they drop the moment it rises.
  always_comb begin
    atk_on_vec = '0;
    for (int i = 0; i < NUM_ATK; i++) begin
      atk_on_vec[i] = !clear && vid_on && (state_q[i] == FLY) && !game_over_q &&
                      (H_count >= (x_q[i] + 17'(HBP))) &&
                      (H_count <= (x_q[i] + 17'(HBP + ATK_SIZE))) &&
                      (V_count >= (y_q[i] + 17'(VBP))) &&
                      (V_count <= (y_q[i] + 17'(VBP + ATK_SIZE)));
    end
    atk_on      = |atk_on_vec;
    game_over   = game_over_q;
    level       = level_q;
    respawn_cnt = resp_q;
  end

endmodule

// File: tb/tb_attacker_array.sv
// tb_attacker_array
//   Directed bench for attacker_array with default parameters. A table
//   of checkpoints (cumulative frame ticks -> expected attacker position,
//   respawn count and level) covers launch staggering, movement and the
//   first respawns; hand-written sequences cover level saturation,
//   respawn saturation, collision, game_stop and clear.
module tb_attacker_array;

  localparam int NA  = 4;
  localparam int HBP = 296;
  localparam int VBP = 35;

  logic          clk_65M = 1'b0;
  logic          clear;
  logic          game_stop;
  logic [16:0]   H_count;
  logic [16:0]   V_count;
  logic          vid_on;
  logic [16:0]   shooter_xmid;
  logic [16:0]   shooter_ymid;
  logic [NA-1:0] atk_on_vec;
  logic          atk_on;
  logic          game_over;
  logic [1:0]    level;
  logic [7:0]    respawn_cnt;

  int vecCount = 0;
  int missCount = 0;
  int curTick = 0;

  // Reference model of attacker positions with shooter out of reach.
  int mx[NA];
  int my[NA];
  bit mf[NA];
  int mcnt, mlvl, mresp;

  typedef struct {
    int ticks;
    int idx;
    int ex;
    int ey;
    bit eon;
    int eresp;
    int elvl;
  } vec_t;

  vec_t vecs[13];

  attacker_array dut (
    .clk_65M      (clk_65M),
    .clear        (clear),
    .game_stop    (game_stop),
    .H_count      (H_count),
    .V_count      (V_count),
    .vid_on       (vid_on),
    .shooter_xmid (shooter_xmid),
    .shooter_ymid (shooter_ymid),
    .atk_on_vec   (atk_on_vec),
    .atk_on       (atk_on),
    .game_over    (game_over),
    .level        (level),
    .respawn_cnt  (respawn_cnt)
  );

  always #5 clk_65M = ~clk_65M;

  task automatic checkOutput(input string name, input int act, input int exp);
    vecCount++;
    if (act != exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tick %0d)", name, act, exp, curTick);
    end
  endtask

  task automatic modelReset;
    for (int i = 0; i < NA; i++) begin
      mx[i] = 627 - 40 * i;
      my[i] = 49;
      mf[i] = 0;
    end
    mcnt  = 0;
    mlvl  = 0;
    mresp = 0;
  endtask

  task automatic modelStep;
    for (int i = 0; i < NA; i++) begin
      if (mf[i] || mcnt == i * 32) begin
        mf[i] = 1;
        if (mx[i] <= 180 || my[i] >= 730) begin
          mx[i] = 627 - 40 * i;
          my[i] = 49;
          mresp++;
        end else begin
          mx[i] = mx[i] - (3 + mlvl);
          my[i] = my[i] + (2 + mlvl);
        end
      end
    end
    if (mcnt < 65535) mcnt++;
    if ((mcnt % 600) == 0 && mlvl < 3) mlvl++;
  endtask

  // One frame tick: raster at (0,0) across a single rising edge.
  task automatic applyStimulus;
    H_count = 17'd0;
    V_count = 17'd0;
    @(posedge clk_65M);
    #1;
    H_count = 17'd1;
    V_count = 17'd1;
    curTick++;
    modelStep();
  endtask

  task automatic runTo(input int target);
    while (curTick < target) applyStimulus();
  endtask

  // Point the raster at an attacker's top-left pixel and one pixel to its left.
  task automatic probe(input string name, input int idx, input int x, input int y, input bit expOn);
    vid_on  = 1'b1;
    H_count = 17'(x + HBP);
    V_count = 17'(y + VBP);
    #1;
    checkOutput({name, "_on"}, int'(atk_on_vec[idx]), int'(expOn));
    if (expOn) begin
      checkOutput({name, "_any"}, int'(atk_on), 1);
      H_count = 17'(x + HBP - 1);
      #1;
      checkOutput({name, "_left"}, int'(atk_on_vec[idx]), 0);
    end
    vid_on  = 1'b0;
    H_count = 17'd1;
    V_count = 17'd1;
  endtask

  task automatic gameStop;
    game_stop = 1'b1;
    @(posedge clk_65M);
    #1;
    game_stop = 1'b0;
    curTick = 0;
    modelReset();
  endtask

  initial begin
    vecs[0]  = '{1,   0, 624, 51,  1, 0, 0};
    vecs[1]  = '{1,   1, 587, 49,  0, 0, 0};
    vecs[2]  = '{32,  1, 587, 49,  0, 0, 0};
    vecs[3]  = '{33,  1, 584, 51,  1, 0, 0};
    vecs[4]  = '{96,  3, 507, 49,  0, 0, 0};
    vecs[5]  = '{97,  3, 504, 51,  1, 0, 0};
    vecs[6]  = '{100, 2, 439, 121, 1, 0, 0};
    vecs[7]  = '{149, 0, 180, 347, 1, 0, 0};
    vecs[8]  = '{150, 0, 627, 49,  1, 1, 0};
    vecs[9]  = '{160, 0, 597, 69,  1, 1, 0};
    vecs[10] = '{168, 1, 179, 321, 1, 1, 0};
    vecs[11] = '{169, 1, 587, 49,  1, 2, 0};
    vecs[12] = '{170, 1, 584, 51,  1, 2, 0};

    clear        = 1'b1;
    game_stop    = 1'b0;
    H_count      = 17'd1;
    V_count      = 17'd1;
    vid_on       = 1'b0;
    shooter_xmid = 17'd2000;
    shooter_ymid = 17'd2000;
    modelReset();
    repeat (3) @(posedge clk_65M);
    #3;
    clear = 1'b0;
    #1;
    checkOutput("rst_game_over", int'(game_over), 0);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_respawn", int'(respawn_cnt), 0);
    probe("rst_atk0_wait", 0, 627, 49, 1'b0);

    // Launch staggering, movement and first respawns.
    foreach (vecs[k]) begin
      runTo(vecs[k].ticks);
      probe($sformatf("vec%0d_atk%0d", k, vecs[k].idx), vecs[k].idx, vecs[k].ex, vecs[k].ey, vecs[k].eon);
      checkOutput($sformatf("vec%0d_respawn", k), int'(respawn_cnt), vecs[k].eresp);
      checkOutput($sformatf("vec%0d_level", k), int'(level), vecs[k].elvl);
      checkOutput($sformatf("vec%0d_game_over", k), int'(game_over), 0);
    end

    // Level steps at 600, 1200, 1800 and then holds.
    runTo(599);  checkOutput("lvl_599", int'(level), 0);
    runTo(600);  checkOutput("lvl_600", int'(level), 1);
    runTo(1199); checkOutput("lvl_1199", int'(level), 1);
    runTo(1200); checkOutput("lvl_1200", int'(level), 2);
    runTo(1800); checkOutput("lvl_1800", int'(level), 3);
    runTo(1801);
    for (int i = 0; i < NA; i++) probe($sformatf("l3_atk%0d", i), i, mx[i], my[i], 1'b1);
    runTo(1802);
    for (int i = 0; i < NA; i++) probe($sformatf("l3b_atk%0d", i), i, mx[i], my[i], 1'b1);
    runTo(2400); checkOutput("lvl_2400", int'(level), 3);
    runTo(3000);
    checkOutput("resp_3000", int'(respawn_cnt), (mresp > 255) ? 255 : mresp);
    runTo(9000);
    checkOutput("resp_sat", int'(respawn_cnt), 255);
    checkOutput("lvl_9000", int'(level), 3);

    // game_stop mid-frame from a busy state.
    gameStop();
    checkOutput("gs_level", int'(level), 0);
    checkOutput("gs_respawn", int'(respawn_cnt), 0);
    checkOutput("gs_game_over", int'(game_over), 0);
    probe("gs_atk0_wait", 0, 627, 49, 1'b0);

    // Collision: one pixel outside the box, then exactly on its edge.
    applyStimulus();
    probe("c_atk0_t1", 0, 624, 51, 1'b1);
    shooter_xmid = 17'd635;
    shooter_ymid = 17'd52;
    applyStimulus();
    checkOutput("c_miss_go", int'(game_over), 0);
    probe("c_atk0_t2", 0, 621, 53, 1'b1);
    shooter_xmid = 17'd614;
    shooter_ymid = 17'd53;
    applyStimulus();
    checkOutput("c_hit_go", int'(game_over), 1);
    probe("c_frozen_hidden", 0, 621, 53, 1'b0);
    repeat (5) applyStimulus();
    checkOutput("c_go_sticky", int'(game_over), 1);
    checkOutput("c_level", int'(level), 0);
    checkOutput("c_respawn", int'(respawn_cnt), 0);

    // Asynchronous clear during game over.
    #2;
    clear = 1'b1;
    #1;
    checkOutput("clr_game_over", int'(game_over), 0);
    checkOutput("clr_atk_on", int'(atk_on), 0);
    @(posedge clk_65M);
    #3;
    clear = 1'b0;
    curTick = 0;
    modelReset();
    shooter_xmid = 17'd2000;
    shooter_ymid = 17'd2000;
    applyStimulus();
    probe("clr_atk0_t1", 0, 624, 51, 1'b1);

    // Collision centred on attacker 0, then game_stop mid-frame.
    shooter_xmid = 17'd625;
    shooter_ymid = 17'd52;
    applyStimulus();
    checkOutput("c2_go", int'(game_over), 1);
    shooter_xmid = 17'd2000;
    shooter_ymid = 17'd2000;
    gameStop();
    checkOutput("gs2_game_over", int'(game_over), 0);
    checkOutput("gs2_level", int'(level), 0);
    checkOutput("gs2_respawn", int'(respawn_cnt), 0);
    probe("gs2_atk0_wait", 0, 627, 49, 1'b0);
    applyStimulus();
    probe("gs2_atk0_t1", 0, 624, 51, 1'b1);

    // atk_on drops combinationally while clear is high.
    vid_on  = 1'b1;
    H_count = 17'(624 + HBP + 1);
    V_count = 17'(51 + VBP + 1);
    #1;
    checkOutput("pre_clr_atk_on", int'(atk_on), 1);
    clear = 1'b1;
    #1;
    checkOutput("clr_vec", int'(atk_on_vec), 0);
    checkOutput("clr_on", int'(atk_on), 0);
    vid_on = 1'b0;
    @(posedge clk_65M);
    #3;
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
